// File: rtl/dct_pkg.sv
// Shared DCT datapath types: stream/PE port payloads and coefficient-ROM geometry.
package dct_pkg;

  localparam int unsigned DCT_W      = 10;
  localparam int unsigned COEF_DEPTH = 8;

  typedef struct packed {
    logic [DCT_W-1:0] data;
    logic             valid;
  } dctPort_t;

  typedef struct packed {
    logic [DCT_W-1:0] coef;
    logic [DCT_W-1:0] acc;
    logic             valid;
  } peRowPort_t;

  typedef struct packed {
    logic [DCT_W-1:0] data;
    logic             load;
    logic             valid;
  } peColPort_t;

endpackage

// File: rtl/dct_if.sv
// Coefficient-ROM read bus between the coefficient map (provider) and the PE arrays (consumer).
interface rom_if #(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned DEPTH      = dct_pkg::COEF_DEPTH
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic                  en;
  logic [AW-1:0]         addr;
  logic [DATA_WIDTH-1:0] data;

  modport tx (input en, input addr, output data);
  modport rx (output en, output addr, input data);
endinterface

// File: rtl/delay_line_ram.sv
// Circular-buffer delay: unreset memory, wrapping pointer, saturating fill counter masks stale reads.
module delay_line_ram #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_ptr;
  logic [FW-1:0]    r_fill;
  logic             w_full;

  assign w_full = (r_fill == FW'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr  <= '0;
      r_fill <= '0;
    end else begin
      r_ptr <= (r_ptr == AW'(DEPTH - 1)) ? '0 : r_ptr + AW'(1);
      if (!w_full) r_fill <= r_fill + FW'(1);
    end
  end

  always_ff @(posedge clk) begin
    r_mem[r_ptr] <= in;
  end

  // Slot under the pointer holds the word written DEPTH-1 edges ago (matches the shift tap).
  assign out = w_full ? r_mem[r_ptr] : '0;
endmodule

// File: rtl/delay_line.sv
// Fixed-latency delay line; out(n) = in(n-DEPTH).
// Define DELAY_LINE_RAM_EN to build DEPTH>=4 instances as a circular buffer.
module delay_line
  import dct_pkg::*;
#(
  parameter int unsigned WIDTH = DCT_W,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);
`ifdef DELAY_LINE_RAM_EN
  localparam bit RAM_EN = 1'b1;
`else
  localparam bit RAM_EN = 1'b0;
`endif

  generate
    if (DEPTH == 0) begin : g_pass
      logic w_unused;
      assign w_unused = clk ^ rst_n;
      assign out      = in;
    end else if (RAM_EN && (DEPTH >= 4)) begin : g_ram
      delay_line_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
      ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .out   (out)
      );
    end else begin : g_shift
      logic [WIDTH-1:0] r_stage [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < int'(DEPTH); k++) r_stage[k] <= '0;
        end else begin
          r_stage[0] <= in;
          for (int k = 1; k < int'(DEPTH); k++) r_stage[k] <= r_stage[k-1];
        end
      end

      assign out = r_stage[DEPTH-1];
    end
  endgenerate
endmodule

// File: tb/tb_delay_line.sv
// Scoreboard bench for delay_line (DEPTH 0/1/4/8) and the rom_if read bus.
module tb_delay_line;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  in_a, out_a;
  logic [10:0] in_b, out_b;
  logic [9:0]  in_c, out_c;
  logic [9:0]  in_d, out_d;

  always #5 clk = ~clk;

  delay_line #(.WIDTH(10), .DEPTH(1)) u_d1 (.clk(clk), .rst_n(rst_n), .in(in_a), .out(out_a));
  delay_line #(.WIDTH(11), .DEPTH(4)) u_d4 (.clk(clk), .rst_n(rst_n), .in(in_b), .out(out_b));
  delay_line #(.WIDTH(10), .DEPTH(0)) u_d0 (.clk(clk), .rst_n(rst_n), .in(in_c), .out(out_c));
  delay_line #(.WIDTH(10), .DEPTH(8)) u_d8 (.clk(clk), .rst_n(rst_n), .in(in_d), .out(out_d));

  rom_if #(.DATA_WIDTH(10), .DEPTH(8)) rom ();

  localparam logic [9:0] EXP_COEF [8] = '{10'h1FF, 10'h0FB, 10'h2A5, 10'h3C0,
                                         10'h001, 10'h155, 10'h3FF, 10'h0A0};

  // 8-entry stub provider
  always_comb begin
    rom.data = '0;
    if (rom.en) begin
      case (rom.addr)
        3'd0: rom.data = 10'h1FF;
        3'd1: rom.data = 10'h0FB;
        3'd2: rom.data = 10'h2A5;
        3'd3: rom.data = 10'h3C0;
        3'd4: rom.data = 10'h001;
        3'd5: rom.data = 10'h155;
        3'd6: rom.data = 10'h3FF;
        default: rom.data = 10'h0A0;
      endcase
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [10:0] q_a[$], q_b[$], q_c[$], q_d[$], q_rom[$];
  logic [10:0] hist [4][9];
  logic        prev_rst_low = 1'b1;

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of stimulus; expected outputs come from an input history cleared by reset.
  task automatic step(input logic rst, input logic [10:0] va, input logic [10:0] vb,
                      input logic [10:0] vc, input logic [10:0] vd);
    logic [10:0] v [4];
    @(posedge clk);
    #1;
    rst_n = rst;
    in_a  = 10'(va);
    in_b  = vb;
    in_c  = 10'(vc);
    in_d  = 10'(vd);
    v = '{va & 11'h3FF, vb, vc & 11'h3FF, vd & 11'h3FF};
    for (int s = 0; s < 4; s++) begin
      for (int k = 8; k > 0; k--) hist[s][k] = hist[s][k-1];
      hist[s][0] = v[s];
      if (!rst || prev_rst_low)
        for (int k = 1; k < 9; k++) hist[s][k] = '0;
    end
    prev_rst_low = !rst;
    q_a.push_back(hist[0][1]);
    q_b.push_back(hist[1][4]);
    q_c.push_back(hist[2][0]);
    q_d.push_back(hist[3][8]);
  endtask

  // Monitor: compare every presented output against the oldest expectation
  initial begin
    forever begin
      @(negedge clk);
      if (q_a.size() > 0)   check("d1_out",  11'(out_a),    q_a.pop_front());
      if (q_b.size() > 0)   check("d4_out",  out_b,         q_b.pop_front());
      if (q_c.size() > 0)   check("d0_out",  11'(out_c),    q_c.pop_front());
      if (q_d.size() > 0)   check("d8_out",  11'(out_d),    q_d.pop_front());
      if (q_rom.size() > 0) check("rom_data", 11'(rom.data), q_rom.pop_front());
    end
  end

  initial begin
    rst_n    = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_c     = '0;
    in_d     = '0;
    rom.en   = 1'b0;
    rom.addr = '0;
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < 9; k++) hist[s][k] = '0;

    // Held in reset: lines read 0, pass-through still follows its input
    for (int i = 0; i < 3; i++)
      step(1'b0, 11'd5, 11'h7FF, 11'($urandom), 11'd7);

    // Ramps on DEPTH 1/8, single-cycle 0x7FF impulse on DEPTH 4, random on DEPTH 0
    for (int i = 1; i <= 20; i++)
      step(1'b1, 11'(i), (i == 3) ? 11'h7FF : 11'h000, 11'($urandom), 11'(i));

    // Mid-stream reset discards in-flight words
    for (int i = 0; i < 2; i++)
      step(1'b0, 11'd100, 11'h7FF, 11'($urandom), 11'd100);

    // New ramp after release: DEPTH 8 shows eight zeros first
    for (int i = 1; i <= 14; i++)
      step(1'b1, 11'(200 + i), 11'h000, 11'($urandom), 11'(200 + i));

    // Random stream long enough to wrap an 8-entry buffer several times
    for (int i = 0; i < 30; i++)
      step(1'b1, 11'($urandom), (i == 5) ? 11'h7FF : 11'h000, 11'($urandom), 11'($urandom));

    // ROM bus: addr sweep with en=1, then en=0 returns zero
    for (int a = 0; a < 8; a++) begin
      @(posedge clk);
      #1;
      rom.en   = 1'b1;
      rom.addr = 3'(a);
      q_rom.push_back(11'(EXP_COEF[a]));
    end
    for (int a = 0; a < 3; a++) begin
      @(posedge clk);
      #1;
      rom.en   = 1'b0;
      rom.addr = 3'(a + 5);
      q_rom.push_back(11'h000);
    end

    @(negedge clk);
    #1;
    if ((q_a.size() + q_b.size() + q_c.size() + q_d.size() + q_rom.size()) != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: expectations left unchecked");
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
